// File: rtl/icefun_keyscan_pkg.sv
// icefun_keyscan_pkg: shared key-matrix geometry, event types and column drive table.
`default_nettype none

package icefun_keyscan_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    key_code_t code;
    logic      press;
  } key_event_t;

  // Element c is the active-low one-hot drive pattern for column c.
  localparam logic [KEY_COLS-1:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

`default_nettype wire

// File: rtl/icefun_keyscan_debounce.sv
// keyscan_debounce: one key's disagreement counter; flips the debounced state after
// DEBOUNCE_SCANS consecutive disagreeing samples and pulses changed on that strobe.
`default_nettype none

module keyscan_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic raw,
  output logic state,
  output logic changed
);

  logic [3:0] cnt;
  logic       differ;

  assign differ  = raw ^ state;
  assign changed = strobe && differ && (cnt == 4'(DEBOUNCE_SCANS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 4'd0;
      state <= 1'b0;
    end else if (strobe) begin
      if (!differ) begin
        cnt <= 4'd0;
      end else if (changed) begin
        cnt   <= 4'd0;
        state <= ~state;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/icefun_keyscan.sv
// icefun_keyscan: 4x4 key matrix scanner with per-key debounce and press/release events.
// Optional macro KEYSCAN_EVENT_FIFO_EN replaces the output holding register with a 4-deep FIFO.
`default_nettype none

module icefun_keyscan
  import icefun_keyscan_pkg::*;
#(
  parameter int BITS_DIV       = 12,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] keys,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_code,
  output logic        ev_press,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int SLOT_W = BITS_DIV - 2;

  logic [BITS_DIV-1:0] timer;
  logic [1:0]          col;
  logic                strobe;
  logic [3:0]          row_s1, row_s2;
  logic [3:0]          raw;
  logic [15:0]         key_changed;
  logic [3:0]          row_changed;
  logic [3:0]          pending;
  logic [1:0]          pend_col;
  logic [1:0]          drain_row;
  logic                drain_hit;
  key_event_t          pend_ev;
  logic                pop;
  logic                drop;

  assign col    = timer[BITS_DIV-1 -: 2];
  assign strobe = &timer[SLOT_W-1:0];
  assign raw    = ~row_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer  <= '0;
      col_n  <= COL_DRIVE[0];
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      timer  <= timer + BITS_DIV'(1);
      col_n  <= COL_DRIVE[col];
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  generate
    for (genvar k = 0; k < KEY_ROWS * KEY_COLS; k++) begin : g_key
      keyscan_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .strobe  (strobe && (col == 2'(k / KEY_ROWS))),
        .raw     (raw[k % KEY_ROWS]),
        .state   (keys[k]),
        .changed (key_changed[k])
      );
    end
  endgenerate

  assign row_changed = key_changed[{col, 2'b00} +: 4];
  assign drain_hit   = |pending;

  always_comb begin
    drain_row = 2'd0;
    for (int r = KEY_ROWS - 1; r >= 0; r--) begin
      if (pending[r]) drain_row = 2'(r);
    end
  end

  // The key state is already flipped when its event drains, so it gives the direction.
  always_comb begin
    pend_ev.code  = {pend_col, drain_row};
    pend_ev.press = keys[{pend_col, drain_row}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 4'd0;
      pend_col <= 2'd0;
    end else begin
      pending <= (pending & ~(drain_hit ? (4'b0001 << drain_row) : 4'b0000)) | row_changed;
      if (strobe) pend_col <= col;
    end
  end

  assign pop = ev_valid && ev_ready;

`ifdef KEYSCAN_EVENT_FIFO_EN
  key_event_t fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push;

  assign ev_valid = (count != 3'd0);
  assign ev_code  = fifo_mem[rd_ptr].code;
  assign ev_press = fifo_mem[rd_ptr].press;
  assign push     = drain_hit && ((count != 3'd4) || pop);
  assign drop     = drain_hit && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= pend_ev;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end
`else
  assign drop = drain_hit && ev_valid && !ev_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_code  <= 4'd0;
      ev_press <= 1'b0;
    end else if (drain_hit && (!ev_valid || ev_ready)) begin
      ev_valid <= 1'b1;
      ev_code  <= pend_ev.code;
      ev_press <= pend_ev.press;
    end else if (pop) begin
      ev_valid <= 1'b0;
    end
  end
`endif

  // A drop in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

`default_nettype wire
